// File: rtl/ifill_responder.sv
// ifill_responder: queues icache misses, fetches lines beat by beat, returns L2 fills.
// Optional: define IFILL_PERF_CNT_EN to add perf_fill_cnt / perf_merge_cnt outputs.
module ifill_responder #(
  parameter  int SET_CNT    = 1024,
  parameter  int CACHE_LINE = 512,
  parameter  int ADDR_SZ    = 32,
  parameter  int BEAT_W     = 64,
  parameter  int REQ_DEPTH  = 4,
  localparam int IDX_W      = $clog2(SET_CNT),
  localparam int OFF_W      = $clog2(CACHE_LINE),
  localparam int TAG_W      = ADDR_SZ - IDX_W - OFF_W,
  localparam int BEATS      = CACHE_LINE / BEAT_W,
  localparam int BIDX_W     = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [TAG_W-1:0]      ic_req_tag,
  input  logic [IDX_W-1:0]      ic_req_index,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_SZ-1:0]    mem_rd_addr,
  input  logic                  mem_rsp_valid,
  input  logic [BEAT_W-1:0]     mem_rsp_data,
  output logic                  fill_valid,
  input  logic                  fill_ready,
  output logic [CACHE_LINE-1:0] fill_data,
  output logic [TAG_W-1:0]      fill_tag,
  output logic [IDX_W-1:0]      fill_index,
  output logic                  fill_is_l2_req,
  output logic [2:0]            fill_op,
  output logic                  busy
`ifdef IFILL_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fill_cnt,
  output logic [31:0]           perf_merge_cnt
`endif
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = BIDX_W + 1;
  localparam logic [CNT_W-1:0] C_BEATS = CNT_W'(BEATS);
  localparam logic [PTR_W:0]   C_DEPTH = (PTR_W + 1)'(REQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT,
    S_RETURN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [TAG_W-1:0]      r_q_tag [REQ_DEPTH];
  logic [IDX_W-1:0]      r_q_idx [REQ_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [PTR_W:0]        r_cnt;
  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_iss_cnt;
  logic [CNT_W-1:0]      r_rsp_cnt;
  logic [CACHE_LINE-1:0] r_line;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_acc;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_merge;
  logic                 w_inf_hit;
  logic [REQ_DEPTH-1:0] w_hit;
  logic                 w_iss;
  logic                 w_rsp;
  logic                 w_fill_hs;
  logic [CNT_W-1:0]     w_iss_nx;
  logic [CNT_W-1:0]     w_rsp_nx;

  assign w_full       = r_cnt == C_DEPTH;
  assign w_empty      = r_cnt == '0;
  assign ic_req_ready = !w_full;
  assign w_acc        = ic_req_valid && !w_full;
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  assign busy         = !w_empty || (r_state != S_IDLE);

  // Duplicate detection against live queue entries, skipping the head being popped.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < REQ_DEPTH; i++) begin
      w_hit[i] = ({1'b0, (PTR_W'(i) - r_head)} < r_cnt)
              && !(w_pop && (PTR_W'(i) == r_head))
              && (r_q_tag[i] == ic_req_tag)
              && (r_q_idx[i] == ic_req_index);
    end
  end

  // The popped head becomes the in-flight line this cycle, so it stands in for it.
  always_comb begin
    if (w_pop) begin
      w_inf_hit = (r_q_tag[r_head] == ic_req_tag)
               && (r_q_idx[r_head] == ic_req_index);
    end else begin
      w_inf_hit = (r_state != S_IDLE)
               && (r_tag == ic_req_tag)
               && (r_idx == ic_req_index);
    end
  end

  assign w_merge   = (|w_hit) || w_inf_hit;
  assign w_push    = w_acc && !w_merge;
  assign w_iss     = (r_state == S_ISSUE) && mem_rd_ready;
  assign w_rsp     = ((r_state == S_ISSUE) || (r_state == S_COLLECT))
                  && mem_rsp_valid && (r_rsp_cnt != C_BEATS);
  assign w_iss_nx  = r_iss_cnt + CNT_W'(w_iss);
  assign w_rsp_nx  = r_rsp_cnt + CNT_W'(w_rsp);
  assign w_fill_hs = fill_valid && fill_ready;

  // Miss queue: circular buffer with head/tail pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        r_q_tag[i] <= '0;
        r_q_idx[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_q_tag[r_tail] <= ic_req_tag;
        r_q_idx[r_tail] <= ic_req_index;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_state_nx   = r_state;
    mem_rd_valid = 1'b0;
    fill_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nx = S_ISSUE;
      end
      S_ISSUE, S_COLLECT: begin
        mem_rd_valid = r_state == S_ISSUE;
        if ((w_iss_nx == C_BEATS) && (w_rsp_nx == C_BEATS)) begin
          w_state_nx = S_RETURN;
        end else if (w_iss_nx == C_BEATS) begin
          w_state_nx = S_COLLECT;
        end
      end
      S_RETURN: begin
        fill_valid = 1'b1;
        if (fill_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // In-flight line: tag/index, beat counters and assembled data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag     <= '0;
      r_idx     <= '0;
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
      r_line    <= '0;
    end else if (w_pop) begin
      r_tag     <= r_q_tag[r_head];
      r_idx     <= r_q_idx[r_head];
      r_iss_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      r_iss_cnt <= w_iss_nx;
      r_rsp_cnt <= w_rsp_nx;
      if (w_rsp) begin
        r_line[r_rsp_cnt[BIDX_W-1:0]*BEAT_W +: BEAT_W] <= mem_rsp_data;
      end
    end
  end

  assign mem_rd_addr    = mem_rd_valid
                        ? {r_tag, r_idx, r_iss_cnt[BIDX_W-1:0],
                           {(OFF_W-BIDX_W){1'b0}}}
                        : '0;
  assign fill_data      = r_line;
  assign fill_tag       = r_tag;
  assign fill_index     = r_idx;
  assign fill_is_l2_req = fill_valid;
  assign fill_op        = fill_valid ? 3'b010 : 3'b000;

`ifdef IFILL_PERF_CNT_EN
  logic [31:0] r_perf_fill;
  logic [31:0] r_perf_merge;

  // Saturating counts of completed fills and merged duplicate requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fill  <= '0;
      r_perf_merge <= '0;
    end else begin
      if (w_fill_hs && (r_perf_fill != '1)) begin
        r_perf_fill <= r_perf_fill + 1'b1;
      end
      if (w_acc && w_merge && (r_perf_merge != '1)) begin
        r_perf_merge <= r_perf_merge + 1'b1;
      end
    end
  end

  assign perf_fill_cnt  = r_perf_fill;
  assign perf_merge_cnt = r_perf_merge;
`else
  logic w_unused;
  assign w_unused = w_fill_hs;
`endif

endmodule

// File: tb/tb_ifill_responder.sv
// tb_ifill_responder: directed bench for ifill_responder.
// Memory model answers each accepted read in order; fills are logged.
`timescale 1ns/1ps
module tb_ifill_responder;

  localparam int TAG_W = 13;
  localparam int IDX_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [TAG_W-1:0]  ic_req_tag;
  logic [IDX_W-1:0]  ic_req_index;
  logic              mem_rd_valid;
  logic              mem_rd_ready;
  logic [31:0]       mem_rd_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [63:0]       mem_rsp_data = '0;
  logic              fill_valid;
  logic              fill_ready;
  logic [511:0]      fill_data;
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_index;
  logic              fill_is_l2_req;
  logic [2:0]        fill_op;
  logic              busy;
`ifdef IFILL_PERF_CNT_EN
  logic [31:0]       perf_fill_cnt;
  logic [31:0]       perf_merge_cnt;
`endif

  ifill_responder dut (
    .clk            (clk),
    .rst            (rst),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_tag     (ic_req_tag),
    .ic_req_index   (ic_req_index),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_ready   (mem_rd_ready),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .fill_valid     (fill_valid),
    .fill_ready     (fill_ready),
    .fill_data      (fill_data),
    .fill_tag       (fill_tag),
    .fill_index     (fill_index),
    .fill_is_l2_req (fill_is_l2_req),
    .fill_op        (fill_op),
    .busy           (busy)
`ifdef IFILL_PERF_CNT_EN
    ,
    .perf_fill_cnt  (perf_fill_cnt),
    .perf_merge_cnt (perf_merge_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_err = 0;
  int          n_chk = 0;
  int          sent = 0;
  int          rsp_limit = 1000000;
  logic [63:0] salt = '0;

  logic [31:0]      pend[$];
  logic [31:0]      rd_log[$];
  logic [TAG_W-1:0] f_tag[$];
  logic [IDX_W-1:0] f_idx[$];
  logic [511:0]     f_data[$];
  logic [3:0]       f_opl[$];

  function automatic logic [63:0] beat(input logic [2:0] i);
    logic [63:0] k;
    k = {61'b0, i};
    return 64'h1111_0000_0000_0000 * k + k;
  endfunction

  function automatic logic [511:0] line(input logic [63:0] s);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = beat(3'(i)) ^ s;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_valid && mem_rd_ready) begin
      pend.push_back(mem_rd_addr);
      rd_log.push_back(mem_rd_addr);
    end
    if (pend.size() != 0 && sent < rsp_limit) begin
      mem_rsp_valid <= 1'b1;
      mem_rsp_data  <= beat(pend[0][8:6]) ^ salt;
      pend.delete(0);
      sent++;
    end else begin
      mem_rsp_valid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (fill_valid && fill_ready) begin
      f_tag.push_back(fill_tag);
      f_idx.push_back(fill_index);
      f_data.push_back(fill_data);
      f_opl.push_back({fill_is_l2_req, fill_op});
    end
  end

  task automatic chk(input string tag, input logic [511:0] o,
                     input logic [511:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s got=%0h want=%0h", tag, o, e);
    end
  endtask

  task automatic req(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] x);
    ic_req_valid = 1'b1;
    ic_req_tag   = t;
    ic_req_index = x;
    @(negedge clk);
    ic_req_valid = 1'b0;
  endtask

  task automatic wait_fills(input int n, input int lim, input string tag);
    int k;
    k = 0;
    while (f_tag.size() < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 512'(f_tag.size() >= n), 512'd1);
  endtask

  task automatic clr();
    rd_log.delete();
    f_tag.delete();
    f_idx.delete();
    f_data.delete();
    f_opl.delete();
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdy"}, 512'(ic_req_ready), 512'd1);
    chk({tag, "_flags"},
        512'({mem_rd_valid, fill_valid, fill_is_l2_req, busy}), 512'd0);
    chk({tag, "_addr"}, 512'(mem_rd_addr), 512'd0);
    chk({tag, "_op"}, 512'(fill_op), 512'd0);
    chk({tag, "_fdata"}, fill_data, 512'd0);
    chk({tag, "_ftagidx"}, 512'({fill_tag, fill_index}), 512'd0);
  endtask

  initial begin
    int k;
    ic_req_valid = 1'b0;
    ic_req_tag   = '0;
    ic_req_index = '0;
    mem_rd_ready = 1'b0;
    fill_ready   = 1'b0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst = 1'b1;
    @(negedge clk);

    // single miss
    mem_rd_ready = 1'b1;
    fill_ready   = 1'b1;
    salt         = '0;
    req(13'h1A, 10'h05);
    wait_fills(1, 100, "t1_timeout");
    chk("t1_nrd", 512'(rd_log.size()), 512'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", 512'((i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF),
          512'({13'h1A, 10'h05, 3'(i), 6'b0}));
    end
    chk("t1_data", f_data[0], line(64'h0));
    chk("t1_tagidx", 512'({f_tag[0], f_idx[0]}), 512'({13'h1A, 10'h05}));
    chk("t1_l2op", 512'(f_opl[0]), 512'(4'b1010));
    @(negedge clk);
    chk("t1_idle", 512'({busy, fill_valid, fill_op}), 512'd0);

    // merge: back-to-back duplicate, then duplicate of in-flight line
    clr();
    salt = 64'hA5A5_0000_5A5A_0000;
    req(13'h1A, 10'h05);
    req(13'h1A, 10'h05);
    repeat (2) @(negedge clk);
    chk("t2_busy", 512'(busy), 512'd1);
    req(13'h1A, 10'h05);
    wait_fills(1, 100, "t2_timeout");
    repeat (30) @(negedge clk);
    chk("t2_nfill", 512'(f_tag.size()), 512'd1);
    chk("t2_nrd", 512'(rd_log.size()), 512'd8);
    chk("t2_data", f_data[0], line(salt));
`ifdef IFILL_PERF_CNT_EN
    chk("t2_perf_merge", 512'(perf_merge_cnt), 512'd2);
    chk("t2_perf_fill", 512'(perf_fill_cnt), 512'd2);
`endif

    // full queue with reads stalled
    clr();
    salt = 64'h0000_3C3C_0000_C3C3;
    mem_rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ic_req_valid = 1'b1;
      ic_req_tag   = 13'h100 + 13'(i);
      ic_req_index = 10'(i + 1);
      if (i == 4) chk("t3_rdy_pre", 512'(ic_req_ready), 512'd1);
      @(negedge clk);
    end
    ic_req_valid = 1'b0;
    chk("t3_full", 512'(ic_req_ready), 512'd0);
    chk("t3_rdv", 512'(mem_rd_valid), 512'd1);
    chk("t3_addr", 512'(mem_rd_addr), 512'({13'h100, 10'h1, 3'b0, 6'b0}));
    ic_req_valid = 1'b1;
    ic_req_tag   = 13'h1FF;
    ic_req_index = 10'h3F;
    repeat (2) @(negedge clk);
    chk("t3_still_full", 512'(ic_req_ready), 512'd0);
    ic_req_valid = 1'b0;
    mem_rd_ready = 1'b1;
    wait_fills(5, 400, "t3_timeout");
    repeat (20) @(negedge clk);
    chk("t3_nfill", 512'(f_tag.size()), 512'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_order", 512'({f_tag[i], f_idx[i]}),
          512'({13'h100 + 13'(i), 10'(i + 1)}));
    end
    chk("t3_data", f_data[4], line(salt));
    chk("t3_rdy_post", 512'(ic_req_ready), 512'd1);

    // fill backpressure with a second miss waiting
    clr();
    salt = 64'h7777_0000_0000_7777;
    fill_ready = 1'b0;
    req(13'h55, 10'h3FF);
    req(13'h56, 10'h3FE);
    k = 0;
    while (!fill_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t4_fv_timeout", 512'(fill_valid), 512'd1);
    for (int c = 0; c < 10; c++) begin
      chk("t4_fv", 512'(fill_valid), 512'd1);
      chk("t4_data", fill_data, line(salt));
      chk("t4_tagidx", 512'({fill_tag, fill_index}), 512'({13'h55, 10'h3FF}));
      chk("t4_no_rd", 512'(mem_rd_valid), 512'd0);
      chk("t4_op", 512'(fill_op), 512'(3'b010));
      @(negedge clk);
    end
    chk("t4_nrd", 512'(rd_log.size()), 512'd8);
    fill_ready = 1'b1;
    wait_fills(2, 100, "t4_timeout");
    chk("t4_first", 512'({f_tag[0], f_idx[0]}), 512'({13'h55, 10'h3FF}));
    chk("t4_second", 512'({f_tag[1], f_idx[1]}), 512'({13'h56, 10'h3FE}));
    chk("t4_data2", f_data[1], line(salt));

    // reset in COLLECT after three beats, then stale beats, then a fresh miss
    clr();
    salt      = 64'h0000_00E1_00E1_0000;
    rsp_limit = sent + 3;
    req(13'h77, 10'h12);
    k = 0;
    while (rd_log.size() < 8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("t5_nrd", 512'(rd_log.size()), 512'd8);
    chk("t5_collect", 512'({busy, fill_valid, mem_rd_valid}), 512'(3'b100));
    chk("t5_pend", 512'(pend.size()), 512'd5);
    rst = 1'b0;
    #1;
    chk_rst("t5_rst");
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    salt      = 64'hDEAD_BEEF_DEAD_BEEF;
    rsp_limit = 1000000;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t5_stale", 512'({busy, fill_valid, mem_rd_valid}), 512'd0);
    end
    chk("t5_drained", 512'(pend.size()), 512'd0);
    chk("t5_nofill", 512'(f_tag.size()), 512'd0);
    clr();
    salt = 64'h4242_0000_4242_0000;
    req(13'h78, 10'h13);
    wait_fills(1, 100, "t5_timeout");
    chk("t5_data", f_data[0], line(salt));
    chk("t5_tagidx", 512'({f_tag[0], f_idx[0]}), 512'({13'h78, 10'h13}));
    chk("t5_addr0", 512'((rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF),
        512'({13'h78, 10'h13, 3'b0, 6'b0}));
`ifdef IFILL_PERF_CNT_EN
    chk("t5_perf_fill", 512'(perf_fill_cnt), 512'd1);
    chk("t5_perf_merge", 512'(perf_merge_cnt), 512'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifill_responder.md
Name: ifill_responder

Overview:
- L2-side responder for instruction-cache miss fills.
- Accepts icache miss requests (tag + set index) and queues them, with duplicate merging.
- Fetches each line from the L2/memory read port as BEAT_W-wide beats, assembles a CACHE_LINE-bit line, and returns it to the icache update stage as an L2 fill (is_l2_req=1, op=3'b010).

Parameters:
- SET_CNT, 1024, number of icache sets; IDX_W = $clog2(SET_CNT)
- CACHE_LINE, 512, line width in bits; OFF_W = $clog2(CACHE_LINE)
- ADDR_SZ, 32, address width; TAG_W = ADDR_SZ - IDX_W - OFF_W
- BEAT_W, 64, memory beat width; BEATS = CACHE_LINE/BEAT_W (power of 2, ≥2); BIDX_W = $clog2(BEATS)
- REQ_DEPTH, 4, miss request queue entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- ic_req_valid  in  1  icache miss request valid
- ic_req_ready  out  1  queue can accept
- ic_req_tag  in  TAG_W  miss tag
- ic_req_index  in  IDX_W  miss set index
- mem_rd_valid  out  1  beat read request valid
- mem_rd_ready  in  1  memory accepts read
- mem_rd_addr  out  ADDR_SZ  beat address
- mem_rsp_valid  in  1  beat data valid (in order, no backpressure)
- mem_rsp_data  in  BEAT_W  beat data
- fill_valid  out  1  assembled line valid
- fill_ready  in  1  icache accepts fill
- fill_data  out  CACHE_LINE  assembled line
- fill_tag  out  TAG_W  tag of fill
- fill_index  out  IDX_W  index of fill
- fill_is_l2_req  out  1  equals fill_valid
- fill_op  out  3  3'b010 while fill_valid, else 3'b000
- busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset (rst=0, async): queue empty, FSM=IDLE, all counters 0. All outputs 0 except ic_req_ready=1. fill_data/fill_tag/fill_index = 0.
- Queue:
  - ic_req_ready = !full; no bypass, so a pop in the same cycle does not free a slot.
  - Accept on valid&&ready.
  - Merge: if {tag,index} equals any valid queue entry, or the in-flight entry while FSM!=IDLE, the request is accepted and discarded.
- FSM IDLE: if queue non-empty, pop head into in-flight regs, clear issue_cnt/rsp_cnt, go to ISSUE. First mem_rd_valid is asserted 2 cycles after the acceptance edge.
- FSM ISSUE:
  - mem_rd_valid=1; mem_rd_addr = {tag, index, issue_cnt, (OFF_W-BIDX_W) zeros}.
  - issue_cnt increments on mem_rd_ready.
  - After the BEATS-th acceptance, drop mem_rd_valid and go to COLLECT.
  - Responses may arrive during ISSUE and are counted.
- Beat capture (ISSUE/COLLECT): on mem_rsp_valid, write mem_rsp_data into line[rsp_cnt*BEAT_W +: BEAT_W] and increment rsp_cnt. When rsp_cnt reaches BEATS (including a last beat arriving in ISSUE) and all beats are issued, go to RETURN.
- FSM RETURN:
  - fill_valid=1; data/tag/index are held stable until fill_ready.
  - On fill_valid&&fill_ready go to IDLE; the next pop happens in the IDLE cycle.
- mem_rsp_valid in IDLE/RETURN: ignored (drops stale beats after reset).
- Simultaneous push and pop on the same entry: pop takes the old head; merge comparison excludes the entry being popped but includes the in-flight copy.
- Counter wrap: issue_cnt and rsp_cnt are BIDX_W+1 bits and never exceed BEATS.

Optional Feature:
- Macro IFILL_PERF_CNT_EN.
- When defined: adds outputs perf_fill_cnt[31:0] (increments per completed fill handshake) and perf_merge_cnt[31:0] (increments per merged request). Both reset to 0, saturate at 32'hFFFF_FFFF.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single miss tag=0x1A, index=0x05, mem_rd_ready=1, beat i data = 64'h1111_0000_0000_0000*i + i, fill_ready=1:
  - 8 reads with addrs {0x1A,0x05,i,6'b0};
  - one fill with fill_data beat i at bits [64i+:64], fill_op=3'b010, fill_is_l2_req=1.
- Merge: request (0x1A,0x05) twice back-to-back, then again while in flight -> exactly one fill; perf_merge_cnt=2 when enabled.
- Full queue: 5 distinct requests with mem_rd_ready=0 -> ic_req_ready=0 after the 5th accept (1 in flight + 4 queued); fills return in request order.
- Backpressure: fill_ready=0 for 10 cycles in RETURN -> fill_valid, fill_data, fill_tag and fill_index stable; no new mem_rd_valid until the handshake.
- Reset mid-COLLECT after 3 beats -> all outputs at reset values; later mem_rsp_valid pulses ignored; a new request gets a correct fill.
